// File: rtl/fwft_fifo_if.sv
// fwft_fifo_if: FIFO bus bundle (CLEAR/WE/W_DATA/RE in; R_DATA/VALID/FILL/FULL/ALMOST_*/OVFLOW/UNFLOW out)
interface fwft_fifo_if #(parameter int D = 4, parameter int W = 16);
  logic         CLEAR;
  logic         WE;
  logic [W-1:0] W_DATA;
  logic         RE;
  logic [W-1:0] R_DATA;
  logic         VALID;
  logic [D:0]   FILL;
  logic         FULL;
  logic         ALMOST_FULL;
  logic         ALMOST_EMPTY;
  logic         OVFLOW;
  logic         UNFLOW;
  modport master (output CLEAR, WE, W_DATA, RE,
                  input  R_DATA, VALID, FILL, FULL, ALMOST_FULL, ALMOST_EMPTY, OVFLOW, UNFLOW);
  modport slave  (input  CLEAR, WE, W_DATA, RE,
                  output R_DATA, VALID, FILL, FULL, ALMOST_FULL, ALMOST_EMPTY, OVFLOW, UNFLOW);
endinterface

// File: rtl/fwft_fifo.sv
// fwft_fifo: first-word-fall-through FIFO; ports CLK, RESET (async high), b (fwft_fifo_if.slave)
module fwft_fifo #(
  parameter int D        = 4,
  parameter int W        = 16,
  parameter int AF_LEVEL = 2**D - 2,
  parameter int AE_LEVEL = 2
) (
  input logic        CLK,
  input logic        RESET,
  fwft_fifo_if.slave b
);
  localparam logic [D:0] CAP = {1'b1, {D{1'b0}}};
  logic [W-1:0] r_mem [2**D];
  logic [W-1:0] r_data;
  logic [D:0]   r_wp, r_rp, r_fill, w_rp_nx;
  logic         r_valid, r_ov, r_un, w_rd, w_wr;
  assign b.FULL         = r_fill == CAP;
  assign b.ALMOST_FULL  = r_fill >= (D+1)'(AF_LEVEL);
  assign b.ALMOST_EMPTY = r_fill <= (D+1)'(AE_LEVEL);
  assign b.FILL         = r_fill;
  assign b.VALID        = r_valid;
  assign b.R_DATA       = r_data;
  assign b.OVFLOW       = r_ov;
  assign b.UNFLOW       = r_un;
  assign w_rd    = b.RE & r_valid;
  assign w_wr    = b.WE & (~b.FULL | w_rd);
  assign w_rp_nx = r_rp + (D+1)'(w_rd);
  // registered read prefetches the head after this edge's pop; a word written on
  // this same edge is not yet visible, giving the one-cycle fall-through latency
  always_ff @(posedge CLK) begin
    if (w_wr && !b.CLEAR) r_mem[r_wp[D-1:0]] <= b.W_DATA;
    r_data <= r_mem[w_rp_nx[D-1:0]];
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_fill  <= '0;
      r_valid <= 1'b0;
      r_ov    <= 1'b0;
      r_un    <= 1'b0;
    end else if (b.CLEAR) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_fill  <= '0;
      r_valid <= 1'b0;
      r_ov    <= 1'b0;
      r_un    <= 1'b0;
    end else begin
      r_wp    <= r_wp + (D+1)'(w_wr);
      r_rp    <= w_rp_nx;
      r_fill  <= r_fill + (D+1)'(w_wr) - (D+1)'(w_rd);
      // head visible only if it was stored before this edge
      r_valid <= w_rp_nx != r_wp;
      r_ov    <= r_ov | (b.WE & ~w_wr);
      r_un    <= r_un | (b.RE & ~r_valid);
    end
  end
endmodule
